div_clk_monitor: RTL and testbench

Measures a divided-clock waveform generated in the `clk` domain, such as the output of the divide-by-N blocks. For each full period of `sig_in` it reports the period and high time in `clk` cycles. It checks the period against the expected division ratio and declares lock after a run of good periods. It is the checking end of the clock-divider path: it is placed on divider outputs in benches, and in silicon as a self-check.

---
 rtl/div_clk_monitor.sv | 150 +++++++++++++++
 tb/tb_div_clk_monitor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// Divided-clock monitor: measures period and high time of sig_in in clk cycles,
// flags ratio errors and declares lock. Optional duty check: DIV_MON_DUTY_CHECK_EN.
module div_clk_monitor #(
  parameter int EXP_DIV = 12,
  parameter int CNT_W   = 8,
  parameter int LOCK_N  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sig_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             ratio_err,
  output logic             duty_err,
  output logic             locked
);

  localparam logic [CNT_W-1:0] EXP_V   = CNT_W'(EXP_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LOCK_M1 = 4'(LOCK_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state;
  logic             sig_d;
  logic             sat;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cap;
  logic [3:0]       match_cnt;

  logic rise;
  logic fall;
  logic ratio_ok;
  logic duty_ok;
  logic good;

  assign rise     = sig_in & ~sig_d;
  assign fall     = ~sig_in & sig_d;
  assign ratio_ok = (cnt == EXP_V) && !sat;
  assign good     = ratio_ok && duty_ok;

`ifdef DIV_MON_DUTY_CHECK_EN
  // Odd ratios accept either neighbour of the half period; even ratios collapse to one value.
  localparam logic [CNT_W-1:0] HALF_LO = CNT_W'(EXP_DIV / 2);
  localparam logic [CNT_W-1:0] HALF_HI = CNT_W'((EXP_DIV + 1) / 2);

  assign duty_ok = (hi_cap == HALF_LO) || (hi_cap == HALF_HI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_err <= 1'b0;
    end else if (en && (state == LOW) && rise && !duty_ok) begin
      duty_err <= 1'b1;
    end else if (err_clr) begin
      duty_err <= 1'b0;
    end
  end
`else
  assign duty_ok  = 1'b1;
  assign duty_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sig_d      <= 1'b1;
      sat        <= 1'b0;
      cnt        <= '0;
      hi_cap     <= '0;
      match_cnt  <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      ratio_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      sig_d      <= sig_in;
      meas_valid <= 1'b0;
      if (err_clr) begin
        ratio_err <= 1'b0;
      end

      if (!en) begin
        state     <= IDLE;
        cnt       <= '0;
        sat       <= 1'b0;
        match_cnt <= '0;
        locked    <= 1'b0;
      end else begin
        if (rise) begin
          cnt <= CNT_ONE;
          sat <= 1'b0;
        end else if (state != IDLE) begin
          if (cnt == CNT_MAX) begin
            sat <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        case (state)
          IDLE: begin
            if (rise) begin
              state <= HIGH;
            end
          end
          HIGH: begin
            if (fall) begin
              state  <= LOW;
              hi_cap <= cnt;
            end
          end
          LOW: begin
            if (rise) begin
              state      <= HIGH;
              period     <= cnt;
              high_time  <= hi_cap;
              meas_valid <= 1'b1;
              if (good) begin
                if (match_cnt < LOCK_M1 + 4'd1) begin
                  match_cnt <= match_cnt + 4'd1;
                end
                if (match_cnt >= LOCK_M1) begin
                  locked <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
                locked    <= 1'b0;
                // A pure duty failure is reported on duty_err only.
                if (!ratio_ok) begin
                  ratio_err <= 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: directed test-plan steps plus random waveforms,
// checked against a sample-history model of the divided clock.
module tb_div_clk_monitor;

  localparam int EXP_DIV = 12;
  localparam int CNT_W   = 8;
  localparam int LOCK_N  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef DIV_MON_DUTY_CHECK_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic             sig_in = 1'b1;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             ratio_err;
  logic             duty_err;
  logic             locked;

  int vectors = 0;
  int miscompares = 0;

  // Model: samples of sig_in since the opening rise of the period in progress.
  logic [0:0] hist_q[$];
  bit armed;
  bit prev_s;
  int run;
  int exp_period;
  int exp_high;
  bit exp_valid;
  bit exp_ratio;
  bit exp_duty;
  bit exp_locked;

  div_clk_monitor #(.EXP_DIV(EXP_DIV), .CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .sig_in(sig_in),
    .err_clr(err_clr),
    .period(period),
    .high_time(high_time),
    .meas_valid(meas_valid),
    .ratio_err(ratio_err),
    .duty_err(duty_err),
    .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("period", 32'(period), exp_period);
    chk("high_time", 32'(high_time), exp_high);
    chk("meas_valid", 32'(meas_valid), 32'(exp_valid));
    chk("ratio_err", 32'(ratio_err), 32'(exp_ratio));
    chk("duty_err", 32'(duty_err), 32'(exp_duty));
    chk("locked", 32'(locked), 32'(exp_locked));
  endtask

  task automatic model_reset();
    hist_q.delete();
    armed = 1'b0;
    prev_s = 1'b1;
    run = 0;
    exp_period = 0;
    exp_high = 0;
    exp_valid = 1'b0;
    exp_ratio = 1'b0;
    exp_duty = 1'b0;
    exp_locked = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic e, input logic c);
    int p;
    int h;
    bit ratio_bad;
    bit duty_bad;
    exp_valid = 1'b0;
    if (c) begin
      exp_ratio = 1'b0;
      exp_duty = 1'b0;
    end
    if (!e) begin
      armed = 1'b0;
      hist_q.delete();
      run = 0;
      exp_locked = 1'b0;
    end else if (s && !prev_s) begin
      if (armed) begin
        p = hist_q.size();
        h = 0;
        foreach (hist_q[i]) if (hist_q[i] == 1'b1) h++;
        exp_period = (p > CNT_MAX) ? CNT_MAX : p;
        exp_high = (h > CNT_MAX) ? CNT_MAX : h;
        exp_valid = 1'b1;
        ratio_bad = (p != EXP_DIV);
        duty_bad = DUTY && !((h == EXP_DIV / 2) || (h == (EXP_DIV + 1) / 2));
        if (ratio_bad) exp_ratio = 1'b1;
        if (duty_bad) exp_duty = 1'b1;
        if (ratio_bad || duty_bad) begin
          run = 0;
          exp_locked = 1'b0;
        end else begin
          run++;
          if (run >= LOCK_N) exp_locked = 1'b1;
        end
      end
      hist_q.delete();
      hist_q.push_back(1'b1);
      armed = 1'b1;
    end else if (armed) begin
      hist_q.push_back(s);
    end
    prev_s = s;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
  task automatic step(input logic s, input logic e, input logic c);
    sig_in = s;
    en = e;
    err_clr = c;
    @(posedge clk);
    model_edge(s, e, c);
    #1;
    check_all();
  endtask

  task automatic drive_period(input int h, input int l);
    for (int i = 0; i < h; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < l; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic nxt;
    model_reset();
    reset = 1'b1;
    sig_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Start-up: sig_in already high at release is not a rise.
    repeat (4) step(1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0);

    // Lock on 6/6.
    repeat (8) drive_period(6, 6);

    // Period change, then clear and relock.
    drive_period(7, 6);
    drive_period(6, 5);
    step(1'b0, 1'b1, 1'b1);
    repeat (5) drive_period(6, 6);

    // Asymmetric duty, then 1-cycle glitches.
    repeat (6) drive_period(8, 4);
    drive_period(1, 11);
    drive_period(11, 1);
    drive_period(1, 1);
    repeat (5) drive_period(6, 6);

    // Saturation.
    drive_period(6, 300);
    repeat (5) drive_period(6, 6);

    // Enable dropped mid-period.
    repeat (3) step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    repeat (6) drive_period(6, 6);

    // Random periods, half of them nominal.
    repeat (60) begin
      if ($urandom_range(0, 1) == 1) drive_period(6, 6);
      else drive_period(int'($urandom_range(1, 9)), int'($urandom_range(1, 9)));
    end

    // Random waveform with random enable drops and clears.
    repeat (600) begin
      nxt = ($urandom_range(0, 3) == 0) ? ~sig_in : sig_in;
      step(nxt, ($urandom_range(0, 49) != 0), ($urandom_range(0, 29) == 0));
    end
    step(1'b0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a locked high phase.
    repeat (6) drive_period(6, 6);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    repeat (3) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (3) drive_period(6, 6);
    step(1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
